ps2_key_tracker: RTL

Downstream consumer of the PS/2 controller's byte stream (`received_data`/`received_data_en`). Parses scan-code set 2 make/break sequences, including the `E0` extended prefix, `F0` break prefix and the 8-byte `E1` Pause sequence. Produces registered held-key levels and single-cycle press/release pulses for the game keys (arrows, space), replacing ad-hoc byte compares in the top level. Its outputs drive game logic and LEDR directly.

---
 rtl/ps2_key_tracker.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// Scan-code set 2 parser for the game keys (arrows, space): tracks held levels
// and emits one-cycle press/release pulses, handling E0/F0 prefixes and the E1 Pause sequence.
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter bit ACCEPT_KEYPAD  = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  // received_data is valid only in a cycle where received_data_en is high;
  // there is no back-pressure, so every strobe is consumed in the cycle it arrives.
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       key_right,
  output logic       key_left,
  output logic       key_up,
  output logic       key_down,
  output logic       key_space,
  output logic [4:0] key_held,
  output logic [4:0] press_pulse,
  output logic [4:0] release_pulse,
  output logic       seq_error,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EXT     = 3'd1;
  localparam logic [2:0] BRK     = 3'd2;
  localparam logic [2:0] EXT_BRK = 3'd3;
  localparam logic [2:0] SKIP    = 3'd4;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d, cur_state;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    held_q, held_d;
  logic [4:0]    press_q, release_q;
  logic          err_q, err_d;
  logic          expire;

  function automatic logic [4:0] key_mask(input logic [7:0] code, input logic ext);
    logic [4:0] m;
    m = 5'b00000;
    case (code)
      8'h74: m = (ext || ACCEPT_KEYPAD) ? 5'b00001 : 5'b00000;
      8'h6B: m = (ext || ACCEPT_KEYPAD) ? 5'b00010 : 5'b00000;
      8'h75: m = (ext || ACCEPT_KEYPAD) ? 5'b00100 : 5'b00000;
      8'h72: m = (ext || ACCEPT_KEYPAD) ? 5'b01000 : 5'b00000;
      8'h29: m = ext ? 5'b00000 : 5'b10000;
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

  // A strobe landing on the expiry cycle is parsed as if the FSM were already in IDLE.
  assign expire    = (state_q != IDLE) && (timer_q == TO_LAST);
  assign cur_state = expire ? IDLE : state_q;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    timer_d = timer_q;
    held_d  = held_q;
    err_d   = 1'b0;
    if (received_data_en) begin
      timer_d = '0;
      case (cur_state)
        IDLE: begin
          state_d = IDLE;
          skip_d  = 3'd0;
          case (received_data)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = SKIP;
              skip_d  = 3'd7;
            end
            8'h00, 8'hFF: begin
              held_d = 5'b00000;
              err_d  = 1'b1;
            end
            default: held_d = held_q | key_mask(received_data, 1'b0);
          endcase
        end
        EXT: begin
          if (received_data == 8'hF0) state_d = EXT_BRK;
          else if (received_data == 8'hE0) state_d = EXT;
          else begin
            held_d  = held_q | key_mask(received_data, 1'b1);
            state_d = IDLE;
          end
        end
        BRK: begin
          held_d  = held_q & ~key_mask(received_data, 1'b0);
          state_d = IDLE;
        end
        EXT_BRK: begin
          held_d  = held_q & ~key_mask(received_data, 1'b1);
          state_d = IDLE;
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            skip_d  = 3'd0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (expire) begin
      state_d = IDLE;
      skip_d  = 3'd0;
      timer_d = '0;
      err_d   = 1'b1;
    end else if (state_q != IDLE) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      skip_q    <= 3'd0;
      timer_q   <= '0;
      held_q    <= 5'b00000;
      press_q   <= 5'b00000;
      release_q <= 5'b00000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      timer_q   <= timer_d;
      held_q    <= held_d;
      press_q   <= held_d & ~held_q;
      release_q <= held_q & ~held_d;
      err_q     <= err_d;
    end
  end

  assign key_right     = held_q[0];
  assign key_left      = held_q[1];
  assign key_up        = held_q[2];
  assign key_down      = held_q[3];
  assign key_space     = held_q[4];
  assign key_held      = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign seq_error     = err_q;
  assign dbg_state     = state_q;

endmodule
